// File: rtl/bsg_gw_bringup_sequencer.sv
// Gateway bring-up sequencer: drives the clock selects, times the clock/core reset
// release, serialises the tag words LSB first and waits for every link to come up.
module bsg_gw_bringup_sequencer #(
  parameter int num_links_p       = 20,
  parameter int tag_width_p       = 16,
  parameter int num_tag_words_p   = 4,
  parameter int clk_rst_cycles_p  = 64,
  parameter int sel_settle_cycles_p = 16,
  parameter int core_rst_cycles_p = 32,
  parameter int tag_gap_cycles_p  = 2,
  parameter int link_timeout_p    = 4096
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     start_i,
  input  logic [2:0]                               sel_i,
  input  logic [num_tag_words_p*tag_width_p-1:0]   tag_payload_i,
  input  logic [num_links_p-1:0]                   link_up_i,
  output logic [2:0]                               sel_o,
  output logic                                     clk_reset_o,
  output logic                                     core_reset_o,
  output logic                                     tag_en_o,
  output logic                                     tag_data_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     error_o
);

  localparam int PW = num_tag_words_p * tag_width_p;
  localparam int TW = (PW > 0) ? PW : 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(sel_settle_cycles_p, clk_rst_cycles_p),
                                     max2(core_rst_cycles_p, tag_gap_cycles_p)),
                                max2(link_timeout_p, tag_width_p));
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int WW = (num_tag_words_p > 1) ? $clog2(num_tag_words_p) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(sel_settle_cycles_p - 1);
  localparam logic [CW-1:0] CLKRST_LAST = CW'(clk_rst_cycles_p - 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(tag_width_p - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(tag_gap_cycles_p - 1);
  localparam logic [CW-1:0] CORE_LAST   = CW'(core_rst_cycles_p - 1);
  localparam logic [CW-1:0] LINK_LAST   = CW'(link_timeout_p - 1);
  localparam logic [WW-1:0] WORD_LAST   = WW'(num_tag_words_p - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL_SETTLE, S_CLK_RST, S_TAG_SHIFT, S_TAG_GAP,
    S_CORE_RST, S_LINK_WAIT, S_DONE, S_ERROR
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_word;
  logic [TW-1:0]   r_tag;
  logic [2:0]      r_sel;
  logic            r_clk_reset;
  logic            r_core_reset;
  logic            r_tag_en;
  logic            r_tag_data;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  // r_tag is a working copy that shifts out one bit per tag cycle; words are
  // contiguous in the payload, so a single shifter covers every word in order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_tag        <= '0;
      r_sel        <= '0;
      r_clk_reset  <= 1'b1;
      r_core_reset <= 1'b1;
      r_tag_en     <= 1'b0;
      r_tag_data   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_state      <= S_SEL_SETTLE;
            r_sel        <= sel_i;
            r_tag        <= TW'(tag_payload_i);
            r_clk_reset  <= 1'b1;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cnt        <= '0;
            r_word       <= '0;
          end
        end
        S_SEL_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= S_CLK_RST;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLK_RST: begin
          if (r_cnt == CLKRST_LAST) begin
            r_clk_reset <= 1'b0;
            r_cnt       <= '0;
            if (num_tag_words_p == 0) begin
              r_state <= S_CORE_RST;
            end else begin
              r_state    <= S_TAG_SHIFT;
              r_tag_en   <= 1'b1;
              r_tag_data <= r_tag[0];
              r_tag      <= r_tag >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_TAG_SHIFT: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (r_word == WORD_LAST) begin
              r_state    <= S_CORE_RST;
              r_tag_en   <= 1'b0;
              r_tag_data <= 1'b0;
            end else begin
              r_word <= r_word + WW'(1);
              if (tag_gap_cycles_p == 0) begin
                r_tag_data <= r_tag[0];
                r_tag      <= r_tag >> 1;
              end else begin
                r_state    <= S_TAG_GAP;
                r_tag_en   <= 1'b0;
                r_tag_data <= 1'b0;
              end
            end
          end else begin
            r_cnt      <= r_cnt + CW'(1);
            r_tag_data <= r_tag[0];
            r_tag      <= r_tag >> 1;
          end
        end
        S_TAG_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state    <= S_TAG_SHIFT;
            r_cnt      <= '0;
            r_tag_en   <= 1'b1;
            r_tag_data <= r_tag[0];
            r_tag      <= r_tag >> 1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CORE_RST: begin
          if (r_cnt == CORE_LAST) begin
            r_state      <= S_LINK_WAIT;
            r_core_reset <= 1'b0;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LINK_WAIT: begin
          // all-links-up takes priority over a coincident timeout
          if (&link_up_i) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == LINK_LAST) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel_o        = r_sel;
  assign clk_reset_o  = r_clk_reset;
  assign core_reset_o = r_core_reset;
  assign tag_en_o     = r_tag_en;
  assign tag_data_o   = r_tag_data;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;

endmodule

// File: tb/tb_bsg_gw_bringup_sequencer.sv
// Bench for the bring-up sequencer: expected outputs per cycle are derived from the
// phase durations (plain arithmetic on the cycle offset from start acceptance).
module tb_bsg_gw_bringup_sequencer;

  localparam int NL = 20;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CR = 64;
  localparam int SS = 16;
  localparam int RC = 32;
  localparam int G  = 2;
  localparam int TO = 4096;

  localparam int T0   = 1 + SS + CR;
  localparam int TEND = T0 + N * W + (N - 1) * G;
  localparam int LW   = TEND + RC;
  localparam logic [9:0] RST_VEC = {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic            start_i;
  logic [2:0]      sel_i;
  logic [N*W-1:0]  tag_payload_i;
  logic [NL-1:0]   link_up_i;
  logic [2:0]      sel_o;
  logic            clk_reset_o, core_reset_o, tag_en_o, tag_data_o;
  logic            busy_o, done_o, error_o;

  int checks   = 0;
  int failures = 0;
  int run_id   = 0;

  always #5 clk = ~clk;

  bsg_gw_bringup_sequencer #(
    .num_links_p(NL), .tag_width_p(W), .num_tag_words_p(N),
    .clk_rst_cycles_p(CR), .sel_settle_cycles_p(SS), .core_rst_cycles_p(RC),
    .tag_gap_cycles_p(G), .link_timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .sel_i(sel_i),
    .tag_payload_i(tag_payload_i), .link_up_i(link_up_i),
    .sel_o(sel_o), .clk_reset_o(clk_reset_o), .core_reset_o(core_reset_o),
    .tag_en_o(tag_en_o), .tag_data_o(tag_data_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  typedef struct {
    logic [2:0]     sel;
    logic [N*W-1:0] payload;
    int             delay;
    int             ignore_d;
    logic [NL-1:0]  down_pat;
    logic           exp_done;
    logic           exp_error;
    logic [2:0]     exp_sel;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [9:0] act();
    return {sel_o, clk_reset_o, core_reset_o, tag_en_o, tag_data_o, busy_o, done_o, error_o};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s act=%b req=%b", name, got, want);
    end
  endtask

  // Order: {sel, clk_reset, core_reset, tag_en, tag_data, busy, done, error}
  function automatic logic [9:0] exp_vec(input int d, input logic [2:0] sel,
                                         input logic [N*W-1:0] pl, input int endd,
                                         input logic is_err);
    logic clk_r, core_r, en, dat, busy, dn, er;
    int rel, w, o;
    clk_r = 1'b0; core_r = 1'b0; en = 1'b0; dat = 1'b0;
    busy = 1'b1; dn = 1'b0; er = 1'b0;
    if (d < T0) begin
      clk_r = 1'b1; core_r = 1'b1;
    end else if (d < TEND) begin
      core_r = 1'b1;
      rel = d - T0;
      w = rel / (W + G);
      o = rel % (W + G);
      if (o < W) begin
        en  = 1'b1;
        dat = pl[w * W + o];
      end
    end else if (d < LW) begin
      core_r = 1'b1;
    end else if (d >= endd) begin
      busy = 1'b0; dn = !is_err; er = is_err;
    end
    return {sel, clk_r, core_r, en, dat, busy, dn, er};
  endfunction

  // delay: cycles after LINK_WAIT entry before all links report up.
  task automatic run_seq(input logic [2:0] sel, input logic [N*W-1:0] pl, input int delay,
                         input int ignore_d, input int abort_d, input logic [NL-1:0] down_pat);
    int endd;
    logic is_err;
    run_id++;
    if (delay <= TO - 1) begin
      endd = LW + delay + 1; is_err = 1'b0;
    end else begin
      endd = LW + TO; is_err = 1'b1;
    end
    start_i = 1'b1; sel_i = sel; tag_payload_i = pl; link_up_i = down_pat;
    @(posedge clk); #1;
    start_i = 1'b0; sel_i = 3'($urandom); tag_payload_i = {$urandom, $urandom};
    for (int d = 1; d <= endd + 2; d++) begin
      check($sformatf("run%0d_cyc%0d", run_id, d), act(), exp_vec(d, sel, pl, endd, is_err));
      if (d == abort_d) begin
        #2 reset_n_i = 1'b0;
        #1 check($sformatf("run%0d_async_rst", run_id), act(), RST_VEC);
        @(posedge clk); #1;
        check($sformatf("run%0d_rst_hold", run_id), act(), RST_VEC);
        #1 reset_n_i = 1'b1;
        @(posedge clk); #1;
        check($sformatf("run%0d_rst_idle", run_id), act(), RST_VEC);
        return;
      end
      start_i = (d == ignore_d);
      if (d == ignore_d) begin
        sel_i = ~sel; tag_payload_i = ~pl;
      end
      if (d < LW)             link_up_i = NL'($urandom);
      else if (d >= LW + delay) link_up_i = '1;
      else                    link_up_i = down_pat;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] pl;
    logic [2:0]     s;
    int             dly;

    tbl[0] = '{sel: 3'b101, payload: {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3}, delay: 0,
               ignore_d: 0, down_pat: 20'hFFF7F, exp_done: 1'b1, exp_error: 1'b0, exp_sel: 3'b101};
    tbl[1] = '{sel: 3'b101, payload: {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3}, delay: 100000,
               ignore_d: 0, down_pat: 20'hFFFFE, exp_done: 1'b0, exp_error: 1'b1, exp_sel: 3'b101};
    tbl[2] = '{sel: 3'b010, payload: 64'h0123_4567_89AB_CDEF, delay: TO - 1,
               ignore_d: 0, down_pat: 20'h7FFFF, exp_done: 1'b1, exp_error: 1'b0, exp_sel: 3'b010};
    tbl[3] = '{sel: 3'b111, payload: 64'hDEAD_BEEF_CAFE_F00D, delay: 10,
               ignore_d: T0 + (W + G) + 3, down_pat: 20'hFDFFF, exp_done: 1'b1, exp_error: 1'b0,
               exp_sel: 3'b111};
    tbl[4] = '{sel: 3'b000, payload: 64'h5555_AAAA_0F0F_F0F0, delay: TO,
               ignore_d: 0, down_pat: 20'hFFFFE, exp_done: 1'b0, exp_error: 1'b1, exp_sel: 3'b000};

    reset_n_i = 1'b0; start_i = 1'b0; sel_i = '0; tag_payload_i = '0; link_up_i = '0;
    #23 reset_n_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_%0d", i), act(), RST_VEC);
      link_up_i = NL'($urandom);
      sel_i = 3'($urandom);
    end

    for (int i = 0; i < 5; i++) begin
      run_seq(tbl[i].sel, tbl[i].payload, tbl[i].delay, tbl[i].ignore_d, 0, tbl[i].down_pat);
      check($sformatf("tbl%0d_end", i), {5'b0, sel_o, done_o, error_o},
            {5'b0, tbl[i].exp_sel, tbl[i].exp_done, tbl[i].exp_error});
    end

    // Reset in the middle of word 2, then a fresh start must replay from word 0.
    pl = {$urandom, $urandom};
    run_seq(3'b110, pl, 0, 0, T0 + 2 * (W + G) + 5, 20'hEFFFF);
    run_seq(3'b110, pl, 4, 0, 0, 20'hEFFFF);

    for (int i = 0; i < 4; i++) begin
      pl  = {$urandom, $urandom};
      s   = 3'($urandom);
      dly = int'($urandom_range(0, 50));
      run_seq(s, pl, dly, 0, 0, ~(NL'(1) << $urandom_range(0, NL - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_gw_bringup_sequencer.md
Name: bsg_gw_bringup_sequencer

Overview:
Gateway-side controller that sequences ASIC bring-up over the socket-to-socket board wiring. It holds the clock-generator reset, drives the clock selects (SEL0..2), releases clock reset, and serialises the configuration words onto the tag lines. It then releases core reset and waits for all IC-to-GW links to report up. It sits in the gateway FPGA between the host/UART control logic and the CLK_RESET/CORE_RESET/SEL/TAG pins.

Parameters:
num_links_p, 20, number of bsg links monitored
tag_width_p, 16, bits per tag word
num_tag_words_p, 4, tag words sent per bring-up
clk_rst_cycles_p, 64, cycles CLK_RESET held after SEL drive
sel_settle_cycles_p, 16, cycles between SEL drive and the clk-reset hold
core_rst_cycles_p, 32, cycles after the last tag word before CORE_RESET release
tag_gap_cycles_p, 2, idle cycles (tag_en_o low) between tag words
link_timeout_p, 4096, max cycles waiting for all links up

Ports:
clk_i  in  1  sequencer clock; also the tag bit clock (TAG_CLK forwarded from clk_i by the wrapper)
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request to begin bring-up; honoured only in IDLE or DONE/ERROR
sel_i  in  3  clock-select value; latched on accepted start_i
tag_payload_i  in  num_tag_words_p*tag_width_p  tag words, word 0 in LSBs; latched on accepted start_i
link_up_i  in  num_links_p  per-link up indication, already synchronised to clk_i
sel_o  out  3  drives SEL2..SEL0
clk_reset_o  out  1  drives CLK_RESET, active-high
core_reset_o  out  1  drives CORE_RESET, active-high
tag_en_o  out  1  high while a tag word is shifting
tag_data_o  out  1  tag serial data, LSB first
busy_o  out  1  high in any state other than IDLE/DONE/ERROR
done_o  out  1  level, high in DONE
error_o  out  1  level, high in ERROR (link timeout)

Behaviour:
- Reset (async assert, sync release): state IDLE; sel_o=0, clk_reset_o=1, core_reset_o=1, tag_en_o=0, tag_data_o=0, busy_o=0, done_o=0, error_o=0; all counters 0.
- States: IDLE -> SEL_SETTLE -> CLK_RST -> TAG_SHIFT <-> TAG_GAP -> CORE_RST -> LINK_WAIT -> DONE | ERROR.
- Accepted start (IDLE/DONE/ERROR & start_i): latch sel_i/tag_payload_i. Next cycle: state=SEL_SETTLE, clk_reset_o=1, core_reset_o=1, sel_o=latched value, done_o/error_o=0. A restart from DONE therefore re-asserts both resets.
- start_i while busy_o=1: ignored; latched values unchanged.
- SEL_SETTLE: sel_settle_cycles_p cycles, then CLK_RST.
- CLK_RST: clk_reset_o stays 1 for clk_rst_cycles_p cycles, then drops to 0 on entry to TAG_SHIFT. Total cycles from start acceptance to clk_reset_o fall = 1+sel_settle_cycles_p+clk_rst_cycles_p.
- TAG_SHIFT: tag_en_o=1 for exactly tag_width_p cycles. tag_data_o = bit k of current word in the k-th cycle.
  - Last bit of word < num_tag_words_p-1: go to TAG_GAP for tag_gap_cycles_p cycles (tag_en_o=0, tag_data_o=0), then shift the next word.
  - Last bit of last word: go to CORE_RST.
  - If num_tag_words_p==0, CLK_RST exits directly to CORE_RST.
- CORE_RST: core_reset_o held 1 for core_rst_cycles_p cycles, then 0 on entry to LINK_WAIT.
- LINK_WAIT: counter runs from 0.
  - &link_up_i sampled high: DONE next cycle. Link-up wins if it coincides with the timeout.
  - Counter reaches link_timeout_p-1 without all links up: ERROR.
- DONE/ERROR: outputs held (clk/core reset stay deasserted); only start_i exits.
- Counters: $clog2(max cycle param + 1) bits; never wrap, they reset on every state entry.
- reset_n_i asserted mid-operation: immediate return to the reset values (clk_reset_o=core_reset_o=1, tag_en_o=0), even mid-word.

Test Plan:
- Reset then idle 100 cycles -> clk_reset_o=1, core_reset_o=1, tag_en_o=0, busy_o=0, sel_o=0.
- start_i with sel_i=3'b101, defaults, link_up_i all 1 -> sel_o=5 one cycle after start; clk_reset_o falls at start+81. Four 16-bit words, LSB first, 2-cycle gaps; core_reset_o falls 32 cycles after the last bit; done_o one cycle later.
- Payload words 16'hA5C3,16'h0001,16'h8000,16'hFFFF -> captured serial stream matches bit-exactly; tag_en_o pulses are exactly 16 cycles each.
- link_up_i = 20'hFFFFE forever -> error_o=1 exactly 4096 cycles after LINK_WAIT entry. Then all ones plus start_i -> full sequence, done_o=1.
- start_i pulsed during TAG_SHIFT with different sel_i/payload -> ignored; stream and sel_o unchanged.
- reset_n_i pulsed low mid-word 2 -> tag_en_o=0, both resets=1 asynchronously; a fresh start replays from word 0.
